// File: rtl/apb_intc_pkg.sv
// rtl/apb_intc_pkg.sv - shared constants and types for the APB interrupt controller
//
// Contents:
//   OFS_*          byte offsets of the register map; only bits [5:2] are decoded
//   CLAIM_VLD_BIT  bit of the CLAIM word that flags "any enabled source pending"
//   NUM_SRC_MIN/MAX legal range of the source count
//   claim_t        priority encoder result {vld, id}
//   claim_word()   packs a claim_t into the 32-bit CLAIM read value

package apb_intc_pkg;

  localparam int NUM_SRC_MIN   = 33;
  localparam int NUM_SRC_MAX   = 64;
  localparam int ID_W          = 6;
  localparam int CLAIM_VLD_BIT = 31;

  localparam logic [11:0] OFS_PEND_L = 12'h000;
  localparam logic [11:0] OFS_PEND_H = 12'h004;
  localparam logic [11:0] OFS_EN_L   = 12'h008;
  localparam logic [11:0] OFS_EN_H   = 12'h00C;
  localparam logic [11:0] OFS_EDGE_L = 12'h010;
  localparam logic [11:0] OFS_EDGE_H = 12'h014;
  localparam logic [11:0] OFS_CLR_L  = 12'h018;
  localparam logic [11:0] OFS_CLR_H  = 12'h01C;
  localparam logic [11:0] OFS_CLAIM  = 12'h020;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } claim_t;

  function automatic logic [31:0] claim_word(input claim_t c);
    logic [31:0] w;
    w                = '0;
    w[CLAIM_VLD_BIT] = c.vld;
    w[ID_W-1:0]      = c.id;
    return w;
  endfunction

endpackage

// File: rtl/apb_intc_prio.sv
// rtl/apb_intc_prio.sv - lowest-index priority encoder over the enabled pending sources
//
// Ports:
//   req    in   N     enabled & pending source vector
//   claim  out  7     {vld, id}; vld = |req, id = lowest set index (0 when none)

module apb_intc_prio
  import apb_intc_pkg::*;
#(
  parameter int N = 40
) (
  input  logic [N-1:0] req,
  output claim_t       claim
);

  // Scanning from the top down lets the lowest set index overwrite
  // everything above it, so the last assignment is the winner.
  always_comb begin
    claim.vld = |req;
    claim.id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        claim.id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_intc.sv
// rtl/apb_intc.sv - APB interrupt controller: source latching, masking, claim and irq
//
// Ports:
//   pclk, preset    clock and synchronous active-high reset
//   psel, penable, pwrite, paddr[11:0], pwdata[31:0], prdata[31:0]
//                   APB slave; no wait states, no error response
//   xx_intc_vld     raw interrupt sources, NUM_SRC bits, synchronous to pclk
//   intc_cpu_irq    registered interrupt request to the core

module apb_intc
  import apb_intc_pkg::*;
#(
  parameter int NUM_SRC = 40
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [11:0]        paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  input  logic [NUM_SRC-1:0] xx_intc_vld,
  output logic               intc_cpu_irq
);

  localparam int HI_W = NUM_SRC - 32;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] en;
  logic [NUM_SRC-1:0] edge_mode;

  logic [NUM_SRC-1:0] en_nxt;
  logic [NUM_SRC-1:0] edge_nxt;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] active;

  logic               hit;
  logic [3:0]         word;
  logic               wr_acc;
  logic               rd_setup;
  logic [31:0]        rd_data;
  claim_t             claim;

  logic [63:0]        pend_w;
  logic [63:0]        en_w;
  logic [63:0]        edge_w;

  // Byte lanes are not decoded; keep the low address bits visibly consumed.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^paddr[1:0];

  // ---------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------
  assign hit      = (paddr[11:6] == 6'd0);
  assign word     = paddr[5:2];
  assign wr_acc   = psel & penable & pwrite & hit;
  assign rd_setup = psel & ~penable & ~pwrite;

  // ---------------------------------------------------------------------
  // Register write path
  // ---------------------------------------------------------------------
  always_comb begin
    en_nxt   = en;
    edge_nxt = edge_mode;
    clr      = '0;
    if (wr_acc) begin
      case (word)
        OFS_EN_L[5:2]:   en_nxt[31:0]           = pwdata;
        OFS_EN_H[5:2]:   en_nxt[NUM_SRC-1:32]   = pwdata[HI_W-1:0];
        OFS_EDGE_L[5:2]: edge_nxt[31:0]         = pwdata;
        OFS_EDGE_H[5:2]: edge_nxt[NUM_SRC-1:32] = pwdata[HI_W-1:0];
        OFS_CLR_L[5:2]:  clr[31:0]              = pwdata;
        OFS_CLR_H[5:2]:  clr[NUM_SRC-1:32]      = pwdata[HI_W-1:0];
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Source latching
  // ---------------------------------------------------------------------
  // The mode seen on this edge is the post-write mode, so an EDGE write
  // takes effect immediately. A held edge-pend survives only if the bit was
  // already in edge mode: switching level->edge discards the level value,
  // and prev tracks the source in both modes so no spurious edge appears.
  // The set term is OR-ed after the clear, so a same-cycle edge beats CLR.
  always_comb begin
    pend_nxt = (xx_intc_vld & ~edge_nxt)
             | (edge_nxt & ((pending & edge_mode & ~clr) | (xx_intc_vld & ~prev)));
  end

  assign active = pending & en;

  always_ff @(posedge pclk) begin
    if (preset) begin
      pending      <= '0;
      prev         <= '0;
      en           <= '0;
      edge_mode    <= '0;
      intc_cpu_irq <= 1'b0;
    end else begin
      pending      <= pend_nxt;
      prev         <= xx_intc_vld;
      en           <= en_nxt;
      edge_mode    <= edge_nxt;
      intc_cpu_irq <= |active;
    end
  end

  // ---------------------------------------------------------------------
  // Claim
  // ---------------------------------------------------------------------
  apb_intc_prio #(
    .N (NUM_SRC)
  ) u_prio (
    .req   (active),
    .claim (claim)
  );

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  // Widening to 64 bits gives the zero-extended high words for any NUM_SRC.
  assign pend_w = 64'(pending);
  assign en_w   = 64'(en);
  assign edge_w = 64'(edge_mode);

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (word)
        OFS_PEND_L[5:2]: rd_data = pend_w[31:0];
        OFS_PEND_H[5:2]: rd_data = pend_w[63:32];
        OFS_EN_L[5:2]:   rd_data = en_w[31:0];
        OFS_EN_H[5:2]:   rd_data = en_w[63:32];
        OFS_EDGE_L[5:2]: rd_data = edge_w[31:0];
        OFS_EDGE_H[5:2]: rd_data = edge_w[63:32];
        OFS_CLAIM[5:2]:  rd_data = claim_word(claim);
        default:         rd_data = '0;
      endcase
    end
  end

  // Captured in the setup phase so the value is stable for the whole
  // access phase; held between reads.
  always_ff @(posedge pclk) begin
    if (preset) begin
      prdata <= '0;
    end else if (rd_setup) begin
      prdata <= rd_data;
    end
  end

endmodule
